// File: rtl/vectored_int_ctrl_if.sv
// Bus bundle between the vectored interrupt controller and its CPU-side master.
// The master drives the interrupt lines and CPU strobes; the controller answers with the request and vector.
interface vectored_int_ctrl_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               clr_we;
  logic [NUM_SRC-1:0] clr_wdata;
  logic               int_ack;
  logic               eret;
  logic               int_req;
  logic [31:0]        int_vector;
  logic [2:0]         int_id;
  logic               in_service;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_wdata, clr_we, clr_wdata, int_ack, eret,
    input  int_req, int_vector, int_id, in_service, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, clr_we, clr_wdata, int_ack, eret,
    output int_req, int_vector, int_id, in_service, pending, mask
  );
endinterface

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, software mask, fixed priority
// (source 0 highest), and a REQ/SERVICE handshake with the CPU. All outputs are registered.
module vectored_int_ctrl #(
  parameter int          NUM_SRC     = 4,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0080,
  parameter int unsigned VEC_STRIDE  = 16
) (
  input  logic                clk,
  input  logic                reset,
  vectored_int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [2:0]         int_id_q;
  logic [31:0]        int_vector_q;
  logic               int_req_q;
  logic               in_service_q;

  logic [NUM_SRC-1:0] rise, eligible, eligible_d, id_onehot, clr_vec;
  logic [2:0]         winner;

  function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] vec_addr(input logic [2:0] id);
    return VECTOR_BASE + ({29'd0, id} * VEC_STRIDE);
  endfunction

  // A new edge always wins over both the software clear and the ack clear.
  always_comb begin
    rise       = bus.irq_in & ~irq_q;
    eligible   = pending_q & mask_q;
    winner     = lowest_idx(eligible);
    id_onehot  = NUM_SRC'(1) << int_id_q;
    clr_vec    = bus.clr_we ? bus.clr_wdata : '0;
    if (state_q == REQ && bus.int_ack) clr_vec = clr_vec | id_onehot;
    pending_d  = (pending_q & ~clr_vec) | rise;
    mask_d     = bus.mask_we ? bus.mask_wdata : mask_q;
    eligible_d = pending_d & mask_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      int_id_q     <= '0;
      int_vector_q <= VECTOR_BASE;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      irq_q     <= bus.irq_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q      <= REQ;
            int_id_q     <= winner;
            int_vector_q <= vec_addr(winner);
            int_req_q    <= 1'b1;
          end
        end
        REQ: begin
          // Ack takes precedence over a withdraw in the same cycle.
          if (bus.int_ack) begin
            state_q      <= SERVICE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (~|(eligible_d & id_onehot)) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eret) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          int_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_vector = int_vector_q;
  assign bus.int_id     = int_id_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed bench for vectored_int_ctrl: linear stimulus with hand-computed expectations.
module tb_vectored_int_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  vectored_int_ctrl_if #(.NUM_SRC(4)) bus ();

  vectored_int_ctrl #(
    .NUM_SRC     (4),
    .VECTOR_BASE (32'h0000_0080),
    .VEC_STRIDE  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic srv,
                         input logic [2:0] id, input logic [31:0] vec, input logic [3:0] pend);
    chk({tag, ".int_req"},    32'(bus.int_req),    32'(req));
    chk({tag, ".in_service"}, 32'(bus.in_service), 32'(srv));
    chk({tag, ".int_id"},     32'(bus.int_id),     32'(id));
    chk({tag, ".int_vector"}, bus.int_vector,      vec);
    chk({tag, ".pending"},    32'(bus.pending),    32'(pend));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset          = 1'b0;
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.clr_we     = 1'b0;
    bus.clr_wdata  = '0;
    bus.int_ack    = 1'b0;
    bus.eret       = 1'b0;

    tick(); tick();
    chk_out("in_reset", 0, 0, 3'd0, 32'h80, 4'b0000);
    chk("in_reset.mask", 32'(bus.mask), 32'h0);
    reset = 1'b1;
    tick();
    chk_out("after_release", 0, 0, 3'd0, 32'h80, 4'b0000);

    // Enable all sources, then a single edge on source 2.
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    chk("mask_write", 32'(bus.mask), 32'hF);
    bus.irq_in = 4'b0100;
    tick();
    chk_out("src2_edge_k", 0, 0, 3'd0, 32'h80, 4'b0100);
    bus.irq_in = 4'b0000;
    tick();
    chk_out("src2_req", 1, 0, 3'd2, 32'hA0, 4'b0100);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk_out("src2_ack", 0, 1, 3'd2, 32'hA0, 4'b0000);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk_out("src2_eret", 0, 0, 3'd2, 32'hA0, 4'b0000);

    // Sources 1 and 3 together: 1 wins, 3 follows after one idle cycle.
    bus.irq_in = 4'b1010;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    chk_out("pair_req1", 1, 0, 3'd1, 32'h90, 4'b1010);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk_out("pair_ack1", 0, 1, 3'd1, 32'h90, 4'b1000);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk_out("pair_idle_gap", 0, 0, 3'd1, 32'h90, 4'b1000);
    tick();
    chk_out("pair_req3", 1, 0, 3'd3, 32'hB0, 4'b1000);

    // Higher priority source 0 arrives during REQ for 3: request stays frozen.
    bus.irq_in = 4'b0001;
    tick();
    bus.irq_in = 4'b0000;
    chk_out("frozen_a", 1, 0, 3'd3, 32'hB0, 4'b1001);
    tick();
    chk_out("frozen_b", 1, 0, 3'd3, 32'hB0, 4'b1001);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk_out("frozen_ack", 0, 1, 3'd3, 32'hB0, 4'b0001);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk_out("src0_gap", 0, 0, 3'd3, 32'hB0, 4'b0001);
    tick();
    chk_out("src0_req", 1, 0, 3'd0, 32'h80, 4'b0001);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk_out("src0_done", 0, 0, 3'd0, 32'h80, 4'b0000);

    // Mask withdraw of source 2, then re-enable.
    bus.irq_in = 4'b0100;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    chk_out("mw_req", 1, 0, 3'd2, 32'hA0, 4'b0100);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1011;
    tick();
    chk_out("mw_withdrawn", 0, 0, 3'd2, 32'hA0, 4'b0100);
    chk("mw_mask", 32'(bus.mask), 32'hB);
    bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    chk_out("mw_reenable_edge", 0, 0, 3'd2, 32'hA0, 4'b0100);
    tick();
    chk_out("mw_reassert", 1, 0, 3'd2, 32'hA0, 4'b0100);

    // Ack together with a new edge on the acked source: set beats ack-clear.
    bus.int_ack = 1'b1; bus.irq_in = 4'b0100;
    tick();
    bus.int_ack = 1'b0;
    chk_out("ack_vs_edge", 0, 1, 3'd2, 32'hA0, 4'b0100);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk_out("ave_eret", 0, 0, 3'd2, 32'hA0, 4'b0100);
    // Stray ack in IDLE: ignored, pending kept, normal REQ follows.
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk_out("stray_ack_idle", 1, 0, 3'd2, 32'hA0, 4'b0100);
    // Stray eret in REQ: ignored.
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk_out("stray_eret_req", 1, 0, 3'd2, 32'hA0, 4'b0100);
    // Withdraw through the pending clear.
    bus.clr_we = 1'b1; bus.clr_wdata = 4'b0100;
    tick();
    bus.clr_we = 1'b0;
    chk_out("clr_withdraw", 0, 0, 3'd2, 32'hA0, 4'b0000);

    // Ack and clear of the latched source in the same cycle: ack wins.
    bus.irq_in = 4'b0000;
    tick();
    bus.irq_in = 4'b0100;
    tick();
    chk_out("avw_pend", 0, 0, 3'd2, 32'hA0, 4'b0100);
    tick();
    chk_out("avw_req", 1, 0, 3'd2, 32'hA0, 4'b0100);
    bus.int_ack = 1'b1; bus.clr_we = 1'b1; bus.clr_wdata = 4'b0100;
    tick();
    bus.int_ack = 1'b0; bus.clr_we = 1'b0;
    chk_out("ack_vs_withdraw", 0, 1, 3'd2, 32'hA0, 4'b0000);

    // Build pending=0110 during SERVICE, then asynchronous reset.
    bus.irq_in = 4'b0010;
    tick();
    bus.irq_in = 4'b0100;
    tick();
    bus.irq_in = 4'b0000;
    chk_out("svc_pending", 0, 1, 3'd2, 32'hA0, 4'b0110);
    reset = 1'b0;
    #2;
    chk_out("async_reset", 0, 0, 3'd0, 32'h80, 4'b0000);
    chk("async_reset.mask", 32'(bus.mask), 32'h0);

    // A line held high through reset registers one edge on the first clock.
    bus.irq_in = 4'b0001;
    tick();
    reset = 1'b1;
    tick();
    chk_out("high_at_release", 0, 0, 3'd0, 32'h80, 4'b0001);
    tick();
    chk_out("high_no_reedge", 0, 0, 3'd0, 32'h80, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vectored_int_ctrl.md
# vectored_int_ctrl

Vectored interrupt controller sitting directly upstream of `mips_top`. It latches external interrupt events, applies a software mask, arbitrates by fixed priority and presents the CPU with a single interrupt request plus the handler vector address. It then tracks the request through acknowledge (exception taken, EPC saved) and `eret` (return from exception).

## Interface
- `NUM_SRC`, 4, number of interrupt sources (1..8)
- `VECTOR_BASE`, 32'h0000_0080, byte address of the source-0 handler
- `VEC_STRIDE`, 16, byte spacing between consecutive handler vectors

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `irq_in`  in  NUM_SRC  interrupt lines, synchronous to `clk`, rising-edge triggered
- `mask_we`  in  1  write strobe for mask register
- `mask_wdata`  in  NUM_SRC  new mask value (1 = enabled)
- `clr_we`  in  1  write strobe for pending-clear
- `clr_wdata`  in  NUM_SRC  write-1-to-clear pending bits
- `int_ack`  in  1  one-cycle pulse: CPU has taken the exception
- `eret`  in  1  one-cycle pulse: CPU executed `eret`
- `int_req`  out  1  interrupt request to CPU
- `int_vector`  out  32  handler address, valid while `int_req`=1
- `int_id`  out  3  index of requested/in-service source
- `in_service`  out  1  handler currently running
- `pending`  out  NUM_SRC  pending register, for readback
- `mask`  out  NUM_SRC  mask register, for readback

## Operation
- Edge detect: `irq_q` register holds the previous sample. Rising edge on source i = `irq_in[i] & ~irq_q[i]`, which sets `pending[i]`.
- Eligible = `pending & mask`. Winner = lowest set index (source 0 highest priority).
- States:
  - IDLE: `int_req`=0, `in_service`=0. Any eligible bit → REQ. `int_id` is latched to the winner.
  - REQ: `int_req`=1. `int_id`/`int_vector` are frozen and do not change if a higher-priority source arrives. `int_ack` → SERVICE and clears `pending[int_id]`. If the latched source stops being eligible (cleared via `clr_we` or masked) without an ack in the same cycle → IDLE (withdraw).
  - SERVICE: `int_req`=0, `in_service`=1, no nesting. New edges still set pending bits. `eret` → IDLE.
- `int_ack` outside REQ and `eret` outside SERVICE are ignored.
- Vector: `int_vector = VECTOR_BASE + int_id * VEC_STRIDE`, 32-bit modulo arithmetic. `int_id` is zero-extended.
- Simultaneous events on the same bit in one cycle:
  - set beats clear: an edge wins over both `clr_we` and the ack-clear.
  - ack beats withdraw: `int_ack` and a clear of the latched source → SERVICE.
- `mask_we` and `clr_we` in the same cycle are both applied. Eligibility in that cycle is evaluated on the old values.
- Reset values: state IDLE; `pending`, `mask`, `irq_q` = 0; `int_id` = 0; `int_vector` = VECTOR_BASE; `int_req` = 0; `in_service` = 0.
- Reset mid-operation aborts REQ/SERVICE immediately and discards all pending events.
- A line already high when reset releases registers one edge on the first clock.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- `irq_in[i]` first sampled high at edge k → `pending[i]`=1 after k. If IDLE with mask set, `int_req`=1 after k+1 (two-cycle latency).
- `int_ack` sampled at edge m → `int_req`=0, `in_service`=1 and `pending` bit clear after m.
- `eret` at edge e → `in_service`=0 after e. If an eligible bit remains, `int_req`=1 after e+1 (minimum one IDLE cycle).
- Withdraw: clear/mask written at edge w → `int_req`=0 after w.
- `mask`/`pending` readback reflects writes after the write edge.

## Test plan
- Reset release with all lines low → every output at its reset value. Then `mask`=4'b1111, pulse `irq_in[2]` → `int_req`=1 two cycles after the first high sample, `int_vector`=32'hA0, `int_id`=2.
- `irq_in[1]` and `irq_in[3]` rise in the same cycle → `int_id`=1, vector 32'h90. After ack and `eret`, → `int_id`=3, vector 32'hB0, with exactly one idle cycle between.
- During REQ for source 3, raise `irq_in[0]` → vector stays 32'hB0 until ack. Source 0 is requested after `eret`.
- Mask source 2 off while it is requested → `int_req` drops the next cycle and `pending[2]` stays 1. Re-enable the mask → request reasserts.
- `int_ack` in the same cycle as a new edge on the acked source → SERVICE entered and `pending` bit still 1. A stray `int_ack` in IDLE and a stray `eret` in REQ → no state change.
- Assert `reset`=0 during SERVICE with pending=4'b0110 → all outputs back to reset values asynchronously, before the next clock edge.
